// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding, RV32 major opcodes and the issue-stage entry layout.
// Both the ALU and the issue stage import this package.
package alu_pkg;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SLL  = 6'd1;
  localparam logic [5:0] ALU_SLT  = 6'd2;
  localparam logic [5:0] ALU_SLTU = 6'd3;
  localparam logic [5:0] ALU_XOR  = 6'd4;
  localparam logic [5:0] ALU_SRL  = 6'd5;
  localparam logic [5:0] ALU_OR   = 6'd6;
  localparam logic [5:0] ALU_AND  = 6'd7;
  localparam logic [5:0] ALU_SRA  = 6'd8;
  localparam logic [5:0] ALU_SUB  = 6'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // One decoded entry as held in the main and skid registers.
  typedef struct packed {
    logic [5:0]  aluop;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } issue_entry_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I OP / OP-IMM / LUI / AUIPC decoder producing ALU opcode,
// operands and writeback control. Illegal encodings produce zeroed operands.
module alu_decoder
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic [5:0]      aluop_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [4:0]      rd_o,
  output logic            rd_we_o,
  output logic            illegal_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic            is_shift;
  logic            legal;
  logic [5:0]      aluop_raw;
  logic [XLEN-1:0] op1_raw;
  logic [XLEN-1:0] op2_raw;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign funct7   = instr_i[31:25];
  assign imm_i    = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u    = {instr_i[31:12], 12'b0};
  assign is_shift = (funct3 == 3'd1) || (funct3 == 3'd5);
  assign rd_o     = instr_i[11:7];

  always_comb begin
    legal     = 1'b0;
    aluop_raw = ALU_ADD;
    op1_raw   = '0;
    op2_raw   = '0;
    unique case (opcode)
      OPC_OP: begin
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
        if ((funct7 == F7_ALT) && (funct3 == 3'd0))      aluop_raw = ALU_SUB;
        else if ((funct7 == F7_ALT) && (funct3 == 3'd5)) aluop_raw = ALU_SRA;
        else                                             aluop_raw = {3'b000, funct3};
        op1_raw = rs1_data_i;
        // The ALU shifts by all of op2, so only the low five bits may survive.
        op2_raw = is_shift ? {27'b0, rs2_data_i[4:0]} : rs2_data_i;
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'd1)      legal = (funct7 == F7_BASE);
        else if (funct3 == 3'd5) legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else                     legal = 1'b1;
        aluop_raw = ((funct3 == 3'd5) && (funct7 == F7_ALT)) ? ALU_SRA : {3'b000, funct3};
        op1_raw   = rs1_data_i;
        op2_raw   = is_shift ? {27'b0, instr_i[24:20]} : imm_i;
      end
      OPC_LUI: begin
        legal   = 1'b1;
        op2_raw = imm_u;
      end
      OPC_AUIPC: begin
        legal   = 1'b1;
        op1_raw = pc_i;
        op2_raw = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  assign illegal_o = !legal;
  assign aluop_o   = legal ? aluop_raw : ALU_ADD;
  assign op1_o     = legal ? op1_raw : '0;
  assign op2_o     = legal ? op2_raw : '0;
  assign rd_we_o   = legal && (rd_o != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// Registered ID/EX issue stage: decodes into ALU operands and holds up to two
// entries (main + skid) so EX sees stable operands under back-pressure.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [5:0]      aluop_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [4:0]      rd_o,
  output logic            rd_we_o,
  output logic            illegal_o
);

  // Handshake: an entry moves on a side exactly when valid && ready are both
  // high at a rising edge; valid never depends combinationally on ready.
  issue_entry_t dec_entry;
  issue_entry_t main_q, main_d;
  issue_entry_t skid_q, skid_d;
  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         accept;
  logic         deliver;

  alu_decoder #(.XLEN(XLEN)) u_decoder (
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .aluop_o    (dec_entry.aluop),
    .op1_o      (dec_entry.op1),
    .op2_o      (dec_entry.op2),
    .rd_o       (dec_entry.rd),
    .rd_we_o    (dec_entry.rd_we),
    .illegal_o  (dec_entry.illegal)
  );

  assign in_ready_o = !skid_valid_q;
  assign accept     = in_valid_i && in_ready_o;
  assign deliver    = main_valid_q && out_ready_i;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || deliver) begin
      // Skid is older than anything arriving, and accept is blocked while it is full.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid_o = main_valid_q;
  assign aluop_o     = main_q.aluop;
  assign op1_o       = main_q.op1;
  assign op2_o       = main_q.op2;
  assign rd_o        = main_q.rd;
  assign rd_we_o     = main_q.rd_we;
  assign illegal_o   = main_q.illegal;

endmodule
